// File: rtl/multicycle_control.sv
// Multi-cycle control unit for an RV32I-subset core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the datapath strobes and muxes.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   instr             instruction register contents (stable from DECODE onward)
//   mem_ready         memory handshake acknowledge (only meaningful while mem_req=1)
//   alu_zero          ALU zero flag, valid in EXEC
//   imm               sign-extended immediate, combinational from instr
//   alu_op            0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLL 7 SRL 8 SRA 9 SLTU
//   alu_src_a         0 rs1, 1 pc, 2 zero;  alu_src_b: 0 rs2, 1 imm
//   wb_sel            0 ALU, 1 load data, 2 pc+4
//   rf_we, mem_req, mem_we, ir_we, pc_we, pc_sel (0 pc+4, 1 pc+imm), illegal
//   state             current state code for debug
module multicycle_control #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_op,
    output logic [1:0]      alu_src_a,
    output logic            alu_src_b,
    output logic [1:0]      wb_sel,
    output logic            rf_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            illegal,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSll  = 4'd6;
    localparam logic [3:0] AluSrl  = 4'd7;
    localparam logic [3:0] AluSra  = 4'd8;
    localparam logic [3:0] AluSltu = 4'd9;

    state_e state_q, state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_op, is_opimm, is_load, is_store, is_branch, is_lui, is_jal, legal;
    logic        br_taken;
    logic [31:0] imm32;
    logic [3:0]  alu_dec;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_load   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_store  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_branch = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_jal    = (opcode == 7'b1101111);
    assign legal     = is_op | is_opimm | is_load | is_store | is_branch | is_lui | is_jal;

    // funct3[0] distinguishes bne from beq
    assign br_taken = funct3[0] ? ~alu_zero : alu_zero;

    always_comb begin
        imm32 = 32'd0;
        unique case (1'b1)
            is_opimm, is_load: imm32 = {{20{instr[31]}}, instr[31:20]};
            is_store:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            is_branch: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            is_lui:    imm32 = {instr[31:12], 12'd0};
            is_jal:    imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    // instr[30] is imm[10] for OP-IMM, so it only selects SUB for register-register ops
    always_comb begin
        alu_dec = AluAdd;
        case (funct3)
            3'b000:  alu_dec = (is_op && instr[30]) ? AluSub : AluAdd;
            3'b001:  alu_dec = AluSll;
            3'b010:  alu_dec = AluSlt;
            3'b011:  alu_dec = AluSltu;
            3'b100:  alu_dec = AluXor;
            3'b101:  alu_dec = instr[30] ? AluSra : AluSrl;
            3'b110:  alu_dec = AluOr;
            default: alu_dec = AluAnd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: state_d = legal ? StExec : StTrap;
            StExec: begin
                if (is_load || is_store) state_d = StMem;
                else if (is_branch)      state_d = StFetch;
                else                     state_d = StWb;
            end
            StMem:    if (mem_ready) state_d = is_load ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    // Everything is held at idle while reset is high, even before the state register updates
    always_comb begin
        alu_op    = AluAdd;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        wb_sel    = 2'd0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                StExec: begin
                    if (is_op || is_opimm) begin
                        alu_op    = alu_dec;
                        alu_src_b = is_opimm;
                    end else if (is_load || is_store) begin
                        alu_src_b = 1'b1;
                    end else if (is_branch) begin
                        alu_op = AluSub;
                        pc_we  = br_taken;
                        pc_sel = br_taken;
                    end else if (is_lui) begin
                        alu_src_a = 2'd2;
                        alu_src_b = 1'b1;
                    end else if (is_jal) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
                StMem: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                end
                StWb: begin
                    rf_we  = 1'b1;
                    wb_sel = is_load ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
                end
                StTrap:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule
